// File: rtl/riscv_pkg.sv
// Shared RV64I+Zba pipeline definitions: opcodes, branch/jump encodings,
// ALU selects and the decoded control bundle carried down the pipeline.
package riscv_pkg;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;

    // Branch condition encoding (0 = not a branch)
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    // Jump encoding (0 = not a jump)
    localparam logic [1:0] JMP_NONE = 2'd0;
    localparam logic [1:0] JMP_JAL  = 2'd1;
    localparam logic [1:0] JMP_JALR = 2'd2;

    // ALU operation selects
    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_SLL    = 5'd2;
    localparam logic [4:0] ALU_SLT    = 5'd3;
    localparam logic [4:0] ALU_SLTU   = 5'd4;
    localparam logic [4:0] ALU_XOR    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_OR     = 5'd8;
    localparam logic [4:0] ALU_AND    = 5'd9;
    localparam logic [4:0] ALU_ADDW   = 5'd10;
    localparam logic [4:0] ALU_SUBW   = 5'd11;
    localparam logic [4:0] ALU_SH1ADD = 5'd12;
    localparam logic [4:0] ALU_SH2ADD = 5'd13;
    localparam logic [4:0] ALU_SH3ADD = 5'd14;
    localparam logic [4:0] ALU_ADDUW  = 5'd15;
    localparam logic [4:0] ALU_PASSB  = 5'd16;

    // Decoded control bundle, registered as one unit by ID/EX
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [2:0] branch;
        logic [1:0] jump;
        logic [4:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Instructions without an rs1 field: LUI, AUIPC, JAL
    function automatic logic opcode_uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    // Only R-type, stores and branches read rs2
    function automatic logic opcode_uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
// Purely combinational; shared with the forwarding logic.
module hazard_unit
    import riscv_pkg::*;
(
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       flush,
    output logic       load_use_stall
);

    logic uses_rs1;
    logic uses_rs2;
    logic rs1_hit;
    logic rs2_hit;

    // Decode which source registers ID reads and compare against the load target
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        uses_rs1       = opcode_uses_rs1(id_opcode);
        uses_rs2       = opcode_uses_rs2(id_opcode);
        rs1_hit        = uses_rs1 && (ex_rd == id_rs1);
        rs2_hit        = uses_rs2 && (ex_rd == id_rs2);
        load_use_stall = 1'b0;
        if (id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) && !flush)
            load_use_stall = rs1_hit || rs2_hit;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV64I+Zba 5-stage pipeline.
// Registers decoded control and operands for EX, inserts one bubble on a
// load-use hazard, holds on downstream stall, squashes on flush, and keeps a
// saturating count of load-use bubbles.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [2:0]       id_funct3,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             id_alu_src,
    input  logic [2:0]       id_branch,
    input  logic [1:0]       id_jump,
    input  logic [4:0]       id_alu_op,
    input  logic             ex_stall,
    input  logic             flush,
    output logic             id_ready,
    output logic             load_use_stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg,
    output logic             ex_alu_src,
    output logic [2:0]       ex_branch,
    output logic [1:0]       ex_jump,
    output logic [4:0]       ex_alu_op,
    output logic [CNT_W-1:0] bubble_count
);

    // Everything the EX slot holds, cleared as a unit for bubbles and flushes
    typedef struct packed {
        logic            valid;
        ctrl_t           ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
    } slot_t;

    slot_t            slot_q;
    slot_t            slot_d;
    ctrl_t            id_ctrl;
    logic [CNT_W-1:0] bubble_q;

    hazard_unit u_hazard (
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .ex_valid       (slot_q.valid),
        .ex_mem_read    (slot_q.ctrl.mem_read),
        .ex_rd          (slot_q.rd),
        .flush          (flush),
        .load_use_stall (load_use_stall)
    );

    assign id_ready = !ex_stall && !load_use_stall && !flush;

    // Bundle the ID fields; an invalid ID slot carries no control so it cannot act
    always_comb begin
        id_ctrl = '{
            reg_write:  id_reg_write,
            mem_read:   id_mem_read,
            mem_write:  id_mem_write,
            mem_to_reg: id_mem_to_reg,
            alu_src:    id_alu_src,
            branch:     id_branch,
            jump:       id_jump,
            alu_op:     id_alu_op
        };
        slot_d = '{
            valid:    id_valid,
            ctrl:     id_valid ? id_ctrl : CTRL_BUBBLE,
            pc:       id_pc,
            rs1_data: id_rs1_data,
            rs2_data: id_rs2_data,
            imm:      id_imm,
            rs1:      id_rs1,
            rs2:      id_rs2,
            rd:       id_rd,
            funct3:   id_funct3
        };
    end

    // EX slot update: flush, then stall-hold, then load-use bubble, then capture
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the whole slot is reset, not only valid, so EX never sees stale
        // operands or indices out of reset; sequential state uses <= only.
        if (!rst_n)
            slot_q <= '0;
        else if (flush)
            slot_q <= '0;
        else if (ex_stall)
            slot_q <= slot_q;
        else if (load_use_stall)
            slot_q <= '0;
        else
            slot_q <= slot_d;
    end

    // Count inserted load-use bubbles, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_q <= '0;
        else if (!flush && !ex_stall && load_use_stall && (bubble_q != '1))
            bubble_q <= bubble_q + 1'b1;
    end

    assign bubble_count  = bubble_q;
    assign ex_valid      = slot_q.valid;
    assign ex_pc         = slot_q.pc;
    assign ex_rs1_data   = slot_q.rs1_data;
    assign ex_rs2_data   = slot_q.rs2_data;
    assign ex_imm        = slot_q.imm;
    assign ex_rs1        = slot_q.rs1;
    assign ex_rs2        = slot_q.rs2;
    assign ex_rd         = slot_q.rd;
    assign ex_funct3     = slot_q.funct3;
    assign ex_reg_write  = slot_q.ctrl.reg_write;
    assign ex_mem_read   = slot_q.ctrl.mem_read;
    assign ex_mem_write  = slot_q.ctrl.mem_write;
    assign ex_mem_to_reg = slot_q.ctrl.mem_to_reg;
    assign ex_alu_src    = slot_q.ctrl.alu_src;
    assign ex_branch     = slot_q.ctrl.branch;
    assign ex_jump       = slot_q.ctrl.jump;
    assign ex_alu_op     = slot_q.ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage. A behavioural model predicts the EX
// slot for each clock; predictions are queued before the edge and compared
// after it. CNT_W is 2 so counter saturation is reachable quickly.
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam int XLEN  = 64;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [2:0]       funct3;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             alu_src;
        logic [2:0]       branch;
        logic [1:0]       jump;
        logic [4:0]       alu_op;
        logic [CNT_W-1:0] bubble;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             id_valid = 1'b0;
    logic [6:0]       id_opcode = '0;
    logic [2:0]       id_funct3 = '0;
    logic [XLEN-1:0]  id_pc = '0;
    logic [4:0]       id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [XLEN-1:0]  id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic             id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic             id_mem_to_reg = 1'b0, id_alu_src = 1'b0;
    logic [2:0]       id_branch = '0;
    logic [1:0]       id_jump = '0;
    logic [4:0]       id_alu_op = '0;
    logic             ex_stall = 1'b0, flush = 1'b0;
    logic             id_ready, load_use_stall, ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [2:0]       ex_funct3;
    logic             ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [2:0]       ex_branch;
    logic [1:0]       ex_jump;
    logic [4:0]       ex_alu_op;
    logic [CNT_W-1:0] bubble_count;

    int   checks = 0;
    int   errors = 0;
    exp_t m = '0;
    exp_t sb[$];

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
        .id_alu_op(id_alu_op), .ex_stall(ex_stall), .flush(flush),
        .id_ready(id_ready), .load_use_stall(load_use_stall), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_op(ex_alu_op),
        .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t dut_state();
        return '{valid: ex_valid, pc: ex_pc, rs1_data: ex_rs1_data,
                 rs2_data: ex_rs2_data, imm: ex_imm, rs1: ex_rs1, rs2: ex_rs2,
                 rd: ex_rd, funct3: ex_funct3, reg_write: ex_reg_write,
                 mem_read: ex_mem_read, mem_write: ex_mem_write,
                 mem_to_reg: ex_mem_to_reg, alu_src: ex_alu_src,
                 branch: ex_branch, jump: ex_jump, alu_op: ex_alu_op,
                 bubble: bubble_count};
    endfunction

    // Drive one ID instruction (control given as a ctrl_t for brevity)
    task automatic set_instr(input logic v, input logic [6:0] op, input logic [2:0] f3,
                             input logic [63:0] pc, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [63:0] imm, input ctrl_t c);
        id_valid = v; id_opcode = op; id_funct3 = f3; id_pc = pc;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_imm = imm;
        id_rs1_data = {$urandom, $urandom};
        id_rs2_data = {$urandom, $urandom};
        id_reg_write = c.reg_write; id_mem_read = c.mem_read;
        id_mem_write = c.mem_write; id_mem_to_reg = c.mem_to_reg;
        id_alu_src = c.alu_src; id_branch = c.branch; id_jump = c.jump;
        id_alu_op = c.alu_op;
    endtask

    task automatic add(input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [63:0] pc);
        set_instr(1'b1, OP_R, 3'd0, pc, rs1, rs2, rd, 64'd0,
                  '{reg_write: 1'b1, alu_op: ALU_ADD, default: '0});
    endtask

    task automatic ld(input logic [4:0] rd, input logic [4:0] rs1, input logic [63:0] pc);
        set_instr(1'b1, OP_LOAD, 3'd3, pc, rs1, 5'd0, rd, 64'd0,
                  '{reg_write: 1'b1, mem_read: 1'b1, mem_to_reg: 1'b1,
                    alu_src: 1'b1, alu_op: ALU_ADD, default: '0});
    endtask

    task automatic sd(input logic [4:0] rs2, input logic [4:0] rs1, input logic [63:0] pc);
        set_instr(1'b1, OP_STORE, 3'd3, pc, rs1, rs2, 5'd0, 64'd0,
                  '{mem_write: 1'b1, alu_src: 1'b1, alu_op: ALU_ADD, default: '0});
    endtask

    // rs2 field of an I-type is imm[4:0]
    task automatic addi(input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [11:0] imm, input logic [63:0] pc);
        set_instr(1'b1, OP_IMM, 3'd0, pc, rs1, imm[4:0], rd, {{52{imm[11]}}, imm},
                  '{reg_write: 1'b1, alu_src: 1'b1, alu_op: ALU_ADD, default: '0});
    endtask

    // One clock: check combinational outputs, predict, clock, compare
    task automatic cycle(input string tag);
        logic u1, u2, lus, rdy;
        exp_t nx, got, want;
        #1;
        u1  = !(id_opcode == 7'h37 || id_opcode == 7'h17 || id_opcode == 7'h6F);
        u2  = (id_opcode == 7'h33 || id_opcode == 7'h23 || id_opcode == 7'h63);
        lus = id_valid && m.valid && m.mem_read && (m.rd != 5'd0) &&
              ((u1 && m.rd == id_rs1) || (u2 && m.rd == id_rs2)) && !flush;
        rdy = !ex_stall && !lus && !flush;
        checks++;
        if (load_use_stall !== lus) begin
            errors++;
            $display("FAIL %s load_use_stall: got %b expected %b", tag, load_use_stall, lus);
        end
        checks++;
        if (id_ready !== rdy) begin
            errors++;
            $display("FAIL %s id_ready: got %b expected %b", tag, id_ready, rdy);
        end
        if (flush) begin
            nx = '0; nx.bubble = m.bubble;
        end else if (ex_stall) begin
            nx = m;
        end else if (lus) begin
            nx = '0;
            nx.bubble = (m.bubble == '1) ? m.bubble : m.bubble + 1'b1;
        end else begin
            nx = '{valid: id_valid, pc: id_pc, rs1_data: id_rs1_data,
                   rs2_data: id_rs2_data, imm: id_imm, rs1: id_rs1, rs2: id_rs2,
                   rd: id_rd, funct3: id_funct3, reg_write: id_reg_write,
                   mem_read: id_mem_read, mem_write: id_mem_write,
                   mem_to_reg: id_mem_to_reg, alu_src: id_alu_src,
                   branch: id_branch, jump: id_jump, alu_op: id_alu_op,
                   bubble: m.bubble};
            if (!id_valid) begin
                nx.reg_write = 0; nx.mem_read = 0; nx.mem_write = 0;
                nx.mem_to_reg = 0; nx.alu_src = 0; nx.branch = '0;
                nx.jump = '0; nx.alu_op = '0;
            end
        end
        sb.push_back(nx);
        @(posedge clk);
        #1;
        got = dut_state();
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            want = sb.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL %s ex slot: got %h expected %h", tag, got, want);
            end
            m = want;
        end
    endtask

    // Hold reset two cycles with random ID inputs, then release off-edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        sb.delete();
        m = '0;
        repeat (2) begin
            set_instr($urandom_range(0, 1), 7'($urandom), 3'($urandom), {$urandom, $urandom},
                      5'($urandom), 5'($urandom), 5'($urandom), {$urandom, $urandom},
                      ctrl_t'($urandom));
            @(posedge clk);
            #1;
            checks++;
            if (dut_state() !== '0) begin
                errors++;
                $display("FAIL %s held: got %h expected 0", tag, dut_state());
            end
        end
        set_instr(1'b0, OP_IMM, 3'd0, 64'd0, 5'd0, 5'd0, 5'd0, 64'd0, CTRL_BUBBLE);
        ex_stall = 0; flush = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset("reset_init");
        add(5'd3, 5'd1, 5'd2, 64'h80);
        cycle("reset_fill");
        // Asynchronous clear: assert mid-cycle, check before the next edge
        rst_n = 1'b0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_pc !== '0 || ex_reg_write !== 1'b0 || bubble_count !== '0) begin
            errors++;
            $display("FAIL reset_async: got valid=%b pc=%h rw=%b cnt=%0d expected all 0",
                     ex_valid, ex_pc, ex_reg_write, bubble_count);
        end
        do_reset("reset");
    endtask

    task automatic test_normal();
        add(5'd3, 5'd1, 5'd2, 64'h100);
        id_rs1_data = 64'd5; id_rs2_data = 64'd7;
        cycle("normal_add");
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 64'h100 || ex_rd !== 5'd3 ||
            ex_alu_op !== 5'd0 || ex_reg_write !== 1'b1 || ex_rs1_data !== 64'd5 ||
            ex_rs2_data !== 64'd7 || id_ready !== 1'b1) begin
            errors++;
            $display("FAIL normal_fields: got v=%b pc=%h rd=%0d op=%0d rw=%b d1=%0d d2=%0d rdy=%b expected 1 100 3 0 1 5 7 1",
                     ex_valid, ex_pc, ex_rd, ex_alu_op, ex_reg_write, ex_rs1_data, ex_rs2_data, id_ready);
        end
    endtask

    task automatic test_load_use();
        ld(5'd5, 5'd1, 64'h200);
        cycle("lu_ld");
        add(5'd6, 5'd5, 5'd1, 64'h204);
        #1;
        checks++;
        if (load_use_stall !== 1'b1 || id_ready !== 1'b0) begin
            errors++;
            $display("FAIL lu_detect: got stall=%b ready=%b expected 1 0", load_use_stall, id_ready);
        end
        cycle("lu_bubble");
        checks++;
        if (ex_valid !== 1'b0 || bubble_count !== 2'd1) begin
            errors++;
            $display("FAIL lu_bubble_state: got valid=%b cnt=%0d expected 0 1", ex_valid, bubble_count);
        end
        cycle("lu_capture");
        checks++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd6 || ex_pc !== 64'h204) begin
            errors++;
            $display("FAIL lu_capture_state: got valid=%b rd=%0d pc=%h expected 1 6 204", ex_valid, ex_rd, ex_pc);
        end
        // LUI whose immediate bits alias rs1 = x5: no rs1 read, no stall
        ld(5'd5, 5'd1, 64'h210);
        cycle("lu_ld2");
        set_instr(1'b1, OP_LUI, 3'd0, 64'h214, 5'd5, 5'd5, 5'd6, 64'h5000,
                  '{reg_write: 1'b1, alu_op: ALU_PASSB, alu_src: 1'b1, default: '0});
        #1;
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_lui: got stall=%b expected 0", load_use_stall);
        end
        cycle("lu_lui_cap");
        // Load to x0 never stalls
        ld(5'd0, 5'd1, 64'h220);
        cycle("lu_ld_x0");
        add(5'd6, 5'd0, 5'd0, 64'h224);
        #1;
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_x0: got stall=%b expected 0", load_use_stall);
        end
        cycle("lu_x0_cap");
    endtask

    task automatic test_store_hazard();
        ld(5'd7, 5'd1, 64'h300);
        cycle("st_ld");
        sd(5'd7, 5'd8, 64'h304);
        #1;
        checks++;
        if (load_use_stall !== 1'b1) begin
            errors++;
            $display("FAIL st_rs2: got stall=%b expected 1", load_use_stall);
        end
        cycle("st_bubble");
        cycle("st_capture");
        // ADDI x9,x8,7: rs2 field is 7 but ADDI does not read rs2
        ld(5'd7, 5'd1, 64'h310);
        cycle("st_ld2");
        addi(5'd9, 5'd8, 12'd7, 64'h314);
        #1;
        checks++;
        if (load_use_stall !== 1'b0) begin
            errors++;
            $display("FAIL st_addi: got stall=%b expected 0", load_use_stall);
        end
        cycle("st_addi_cap");
    endtask

    task automatic test_stall_flush();
        add(5'd3, 5'd1, 5'd2, 64'h400);
        cycle("sf_add");
        add(5'd4, 5'd3, 5'd3, 64'h404);
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (id_ready !== 1'b0) begin
                errors++;
                $display("FAIL sf_ready_%0d: got %b expected 0", i, id_ready);
            end
            cycle("sf_hold");
            checks++;
            if (ex_valid !== 1'b1 || ex_pc !== 64'h400 || ex_rd !== 5'd3) begin
                errors++;
                $display("FAIL sf_hold_%0d: got v=%b pc=%h rd=%0d expected 1 400 3", i, ex_valid, ex_pc, ex_rd);
            end
        end
        flush = 1'b1;
        cycle("sf_flush");
        checks++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_alu_op !== 5'd0 || ex_pc !== '0) begin
            errors++;
            $display("FAIL sf_flush_state: got v=%b rw=%b op=%0d pc=%h expected 0 0 0 0",
                     ex_valid, ex_reg_write, ex_alu_op, ex_pc);
        end
        ex_stall = 1'b0; flush = 1'b0;
        // Flush masks a pending load-use hazard
        ld(5'd5, 5'd1, 64'h410);
        cycle("sf_ld");
        add(5'd6, 5'd5, 5'd2, 64'h414);
        flush = 1'b1;
        cycle("sf_flush_lu");
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            logic [4:0] a, b, d;
            a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: add(d, a, b, 64'h1000 + 64'(i * 4));
                1: ld(d, a, 64'h1000 + 64'(i * 4));
                2: sd(b, a, 64'h1000 + 64'(i * 4));
                default: addi(d, a, 12'($urandom), 64'h1000 + 64'(i * 4));
            endcase
            id_valid = ($urandom_range(0, 5) != 0);
            ex_stall = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            cycle("b2b");
        end
        ex_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset("sat_reset");
        for (int i = 0; i < 5; i++) begin
            ld(5'd5, 5'd1, 64'h500);
            cycle("sat_ld");
            add(5'd6, 5'd5, 5'd2, 64'h504);
            cycle("sat_bubble");
            checks++;
            if (bubble_count !== sat_exp[i]) begin
                errors++;
                $display("FAIL sat_%0d: got %0d expected %0d", i, bubble_count, sat_exp[i]);
            end
            cycle("sat_capture");
        end
    endtask

    task automatic test_reset_mid_stall();
        ld(5'd5, 5'd1, 64'h600);
        cycle("rms_ld");
        add(5'd6, 5'd5, 5'd2, 64'h604);
        #1;
        checks++;
        if (load_use_stall !== 1'b1) begin
            errors++;
            $display("FAIL rms_pre: got stall=%b expected 1", load_use_stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (load_use_stall !== 1'b0 || ex_valid !== 1'b0 || ex_mem_read !== 1'b0 ||
            bubble_count !== '0 || id_ready !== 1'b1) begin
            errors++;
            $display("FAIL rms_clear: got stall=%b v=%b mr=%b cnt=%0d rdy=%b expected 0 0 0 0 1",
                     load_use_stall, ex_valid, ex_mem_read, bubble_count, id_ready);
        end
        do_reset("rms_reset");
        add(5'd3, 5'd1, 5'd2, 64'h700);
        cycle("rms_after");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_load_use();
        test_store_hazard();
        test_stall_flush();
        test_back_to_back();
        test_saturation();
        test_reset_mid_stall();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
